uart_rx: RTL and testbench

Asynchronous serial receiver that pairs with the `uart_tx` transmitter. It synchronises the `rx` line and detects the start bit. It samples each bit at mid-bit and checks optional parity and the stop bit. Each received frame goes out on a valid/ready output with parity-error and framing-error flags. It connects directly to the serial line driven by a `uart_tx` with identical parameters, and is the consumer used in loopback benches.

---
 rtl/uart_rx.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Asynchronous serial receiver. Synchronises the rx line,
//               detects the start bit on a falling edge, samples every bit
//               at mid-bit, checks optional parity and the stop bit, and
//               presents each frame on a one-entry valid/ready holding
//               register with parity and framing error flags.
// Ports       : clk     - single clock, rising edge
//               rst     - asynchronous active-low reset
//               rx      - serial line, idle high, asynchronous to clk
//               o_vld   - frame available on o_data/o_perr/o_ferr
//               i_rdy   - consumer accepts when o_vld && i_rdy
//               o_data  - received data, bit 0 = first data bit on the line
//               o_perr  - parity mismatch (always 0 without parity)
//               o_ferr  - stop bit sampled as 0
//               o_ovr   - one-cycle pulse: a completed frame was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int    DATA_WIDTH   = 8,
    parameter string PARITY_CHECK = "NONE",
    parameter int    CLK_FREQ     = 50000000,
    parameter int    BAUD_RATE    = 9600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_perr,
    output logic                  o_ferr,
    output logic                  o_ovr
);

    localparam int c_BIT      = CLK_FREQ / BAUD_RATE;
    localparam int c_HALF     = c_BIT / 2;
    localparam int c_CW       = $clog2(c_BIT);
    localparam int c_IW       = $clog2(DATA_WIDTH);
    localparam bit c_PAR_EN   = (PARITY_CHECK != "NONE");
    localparam bit c_PAR_ODD  = (PARITY_CHECK == "ODD");

    localparam logic [c_CW-1:0] c_BIT_LOAD  = c_CW'(c_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LOAD = c_CW'(c_HALF - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_width
        $fatal(1, "uart_rx: DATA_WIDTH must be in 2..8");
    end
    if (PARITY_CHECK != "NONE" && PARITY_CHECK != "ODD" && PARITY_CHECK != "EVEN") begin : g_bad_parity
        $fatal(1, "uart_rx: PARITY_CHECK must be NONE, ODD or EVEN");
    end
    if (c_BIT < 4) begin : g_bad_baud
        $fatal(1, "uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                  r_sync1;
    logic                  r_rx_s;
    logic                  r_rx_p;
    state_t                r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [c_IW-1:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bit;
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_ovr;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [c_CW-1:0]       w_cnt_nxt;
    logic [c_IW-1:0]       w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_par_bit_nxt;
    logic                  w_tick;
    logic                  w_done;
    logic                  w_par_exp;
    logic                  w_frame_perr;
    logic                  w_frame_ferr;

    // ------------------------------------------------------------------
    // Input synchroniser; flops reset high so a released reset on an idle
    // line never looks like a start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_p  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_p  <= r_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_bit <= w_par_bit_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: next state. The counter is a down-counter reloaded at
    // every sample point; a sample is taken on the cycle it reads zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_par_bit_nxt = r_par_bit;
        w_done        = 1'b0;
        w_tick        = (r_cnt == '0);

        case (r_state)
            S_IDLE: begin
                // Edge rather than level, so a held-low line cannot retrigger
                if (r_rx_p && !r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = c_HALF_LOAD;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = c_BIT_LOAD;
                        w_idx_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CW'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                    w_cnt_nxt   = c_BIT_LOAD;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = c_PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CW'(1);
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_par_bit_nxt = r_rx_s;
                    w_cnt_nxt     = c_BIT_LOAD;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt - c_CW'(1);
                end
            end
            S_STOP: begin
                // Returning to IDLE mid-stop-bit leaves half a bit of slack
                // for the next start edge of a back-to-back stream.
                if (w_tick) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Odd parity expects the complement of the data XOR so that the total
    // count of ones including the parity bit is odd.
    assign w_par_exp    = c_PAR_ODD ? ~^r_shift : ^r_shift;
    assign w_frame_perr = c_PAR_EN & (r_par_bit != w_par_exp);
    assign w_frame_ferr = ~r_rx_s;

    // ------------------------------------------------------------------
    // One-entry output holding register. A completing frame may load on
    // the same cycle the current entry is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_done) begin
                if (!r_vld || i_rdy) begin
                    r_vld  <= 1'b1;
                    r_data <= r_shift;
                    r_perr <= w_frame_perr;
                    r_ferr <= w_frame_ferr;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_vld && i_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_perr = r_perr;
    assign o_ferr = r_ferr;
    assign o_ovr  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Three receivers (no parity,
//               odd, even) on separate lines; a bench-side serial driver
//               plays the transmitter and a scoreboard queue holds the
//               frames each receiver is expected to deliver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BIT = 10;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rxl = 3'b111;
    logic [2:0] rdy = 3'b111;
    wire  [2:0] vld;
    wire  [2:0] perr;
    wire  [2:0] ferr;
    wire  [2:0] ovr;
    wire  [7:0] dat [3];

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   frames   [3] = '{0, 0, 0};
    int   ovr_cnt  [3] = '{0, 0, 0};
    int   rise_cyc [3] = '{-1, -1, -1};
    logic [2:0] vld_d = 3'b000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.DATA_WIDTH(8), .PARITY_CHECK("NONE"), .CLK_FREQ(1000000), .BAUD_RATE(100000)) u_none (
        .clk(clk), .rst(rst), .rx(rxl[0]), .o_vld(vld[0]), .i_rdy(rdy[0]),
        .o_data(dat[0]), .o_perr(perr[0]), .o_ferr(ferr[0]), .o_ovr(ovr[0]));
    uart_rx #(.DATA_WIDTH(8), .PARITY_CHECK("ODD"), .CLK_FREQ(1000000), .BAUD_RATE(100000)) u_odd (
        .clk(clk), .rst(rst), .rx(rxl[1]), .o_vld(vld[1]), .i_rdy(rdy[1]),
        .o_data(dat[1]), .o_perr(perr[1]), .o_ferr(ferr[1]), .o_ovr(ovr[1]));
    uart_rx #(.DATA_WIDTH(8), .PARITY_CHECK("EVEN"), .CLK_FREQ(1000000), .BAUD_RATE(100000)) u_even (
        .clk(clk), .rst(rst), .rx(rxl[2]), .o_vld(vld[2]), .i_rdy(rdy[2]),
        .o_data(dat[2]), .o_perr(perr[2]), .o_ferr(ferr[2]), .o_ovr(ovr[2]));

    // Output monitor: pops the scoreboard on every accepted frame.
    always @(negedge clk) begin
        exp_t e;
        for (int ch = 0; ch < 3; ch++) begin
            if (ovr[ch] === 1'b1) ovr_cnt[ch]++;
            if (vld[ch] === 1'b1 && vld_d[ch] !== 1'b1) rise_cyc[ch] = cyc;
            if (vld[ch] === 1'b1 && rdy[ch] === 1'b1) begin
                frames[ch]++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL frame_unexpected ch%0d: got data=%02h perr=%b ferr=%b, required no frame",
                             ch, dat[ch], perr[ch], ferr[ch]);
                end else begin
                    e = sb.pop_front();
                    if (e.ch !== 2'(ch) || dat[ch] !== e.data || perr[ch] !== e.perr || ferr[ch] !== e.ferr) begin
                        fails++;
                        $display("FAIL frame_check ch%0d: got data=%02h perr=%b ferr=%b, required ch%0d data=%02h perr=%b ferr=%b",
                                 ch, dat[ch], perr[ch], ferr[ch], e.ch, e.data, e.perr, e.ferr);
                    end
                end
            end
        end
        vld_d = vld;
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int ch, input logic v);
        rxl[ch] = v;
        wait_cyc(BIT);
    endtask

    // Leaves the line at the stop-bit level on return.
    task automatic send_frame(input int ch, input logic [7:0] d, input bit has_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(ch, 1'b0);
        for (int k = 0; k < 8; k++) drive_bit(ch, d[k]);
        if (has_par) drive_bit(ch, par_bit);
        drive_bit(ch, stop_bit);
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_cyc(3);
        for (int ch = 0; ch < 3; ch++) begin
            tests++;
            if ({vld[ch], dat[ch], perr[ch], ferr[ch], ovr[ch]} !== 12'h000) begin
                fails++;
                $display("FAIL reset_hold ch%0d: got vld=%b data=%h perr=%b ferr=%b ovr=%b, required all 0",
                         ch, vld[ch], dat[ch], perr[ch], ferr[ch], ovr[ch]);
            end
        end
        rst = 1'b1;
        wait_cyc(3);
        for (int ch = 0; ch < 3; ch++) begin
            tests++;
            if ({vld[ch], dat[ch], perr[ch], ferr[ch], ovr[ch]} !== 12'h000) begin
                fails++;
                $display("FAIL reset_release ch%0d: got vld=%b data=%h perr=%b ferr=%b ovr=%b, required all 0",
                         ch, vld[ch], dat[ch], perr[ch], ferr[ch], ovr[ch]);
            end
        end
    endtask

    // o_vld is expected 98 cycles after the start bit is driven:
    // 2 synchroniser cycles, stop sample at +95 from detection, +1 register.
    task automatic test_none_timing();
        int start;
        rise_cyc[0] = -1;
        push(0, 8'hA5, 1'b0, 1'b0);
        start = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        tests++;
        if (rise_cyc[0] - start != 98) begin
            fails++;
            $display("FAIL none_latency: got o_vld rise at +%0d cycles, required +98", rise_cyc[0] - start);
        end
        tests++;
        if (vld[0] !== 1'b0) begin
            fails++;
            $display("FAIL none_vld_pulse: got o_vld=%b after accept, required 0", vld[0]);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL none_delivered: got %0d frames pending, required 0", sb.size());
        end
    endtask

    task automatic test_odd_parity();
        push(1, 8'h03, 1'b0, 1'b0);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        push(1, 8'h03, 1'b1, 1'b0);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        wait_cyc(2);
        tests++;
        if (frames[1] != 2 || sb.size() != 0) begin
            fails++;
            $display("FAIL odd_count: got %0d frames (%0d pending), required 2 (0 pending)", frames[1], sb.size());
        end
    endtask

    task automatic test_framing();
        int n;
        push(0, 8'h5A, 1'b0, 1'b1);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        n = frames[0];
        wait_cyc(30);
        tests++;
        if (frames[0] != n || vld[0] !== 1'b0) begin
            fails++;
            $display("FAIL break_no_retrigger: got %0d extra frames vld=%b, required 0 and 0", frames[0] - n, vld[0]);
        end
        rxl[0] = 1'b1;
        wait_cyc(20);
        push(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_cyc(2);
        tests++;
        if (frames[0] != n + 1 || sb.size() != 0) begin
            fails++;
            $display("FAIL break_recover: got %0d new frames, required 1", frames[0] - n);
        end
    endtask

    task automatic test_glitch();
        int n;
        n = frames[0];
        rxl[0] = 1'b0;
        wait_cyc(3);
        rxl[0] = 1'b1;
        wait_cyc(30);
        tests++;
        if (frames[0] != n || vld[0] !== 1'b0) begin
            fails++;
            $display("FAIL glitch_reject: got %0d frames vld=%b, required 0 and 0", frames[0] - n, vld[0]);
        end
        push(0, 8'h81, 1'b0, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_cyc(2);
        tests++;
        if (frames[0] != n + 1) begin
            fails++;
            $display("FAIL glitch_then_frame: got %0d frames, required 1", frames[0] - n);
        end
    endtask

    task automatic test_back_to_back();
        int o;
        o = ovr_cnt[0];
        rdy[0] = 1'b0;
        push(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        tests++;
        if (vld[0] !== 1'b1 || dat[0] !== 8'h11) begin
            fails++;
            $display("FAIL ovr_hold: got vld=%b data=%02h, required vld=1 data=11", vld[0], dat[0]);
        end
        tests++;
        if (ovr_cnt[0] != o + 1) begin
            fails++;
            $display("FAIL ovr_pulse: got %0d o_ovr pulses, required 1", ovr_cnt[0] - o);
        end
        push(0, 8'h33, 1'b0, 1'b0);
        fork
            send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
            begin
                // Stop sample of this frame falls in cycle +97
                wait_cyc(97);
                rdy[0] = 1'b1;
            end
        join
        wait_cyc(2);
        tests++;
        if (ovr_cnt[0] != o + 1) begin
            fails++;
            $display("FAIL ovr_same_cycle_load: got %0d o_ovr pulses, required 1", ovr_cnt[0] - o);
        end
        tests++;
        if (sb.size() != 0 || vld[0] !== 1'b0) begin
            fails++;
            $display("FAIL ovr_drain: got %0d pending vld=%b, required 0 pending vld=0", sb.size(), vld[0]);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] d;
        int base;
        base = frames[2];
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                // 0xF8 with even parity: line is high from data bit 3 to the
                // end of the frame, so reset lands on a high line and no edge
                // follows; this frame must never appear.
                fork
                    send_frame(2, 8'hF8, 1'b1, 1'b1, 1'b1);
                    begin
                        wait_cyc(55);
                        rst = 1'b0;
                        wait_cyc(3);
                        rst = 1'b1;
                    end
                join
            end
            d = 8'($urandom);
            push(2, d, 1'b0, 1'b0);
            send_frame(2, d, 1'b1, ^d, 1'b1);
        end
        wait_cyc(5);
        tests++;
        if (frames[2] - base != 256 || sb.size() != 0) begin
            fails++;
            $display("FAIL loopback_count: got %0d frames (%0d pending), required 256 (0 pending)",
                     frames[2] - base, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_none_timing();
        test_odd_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
